// File: rtl/face_scan_sequencer_if.sv
// Handshake bundle between the face scan sequencer, the solve FSM, the motion controller and the classifier.
// The slave modport is the sequencer side; the master modport drives start, move_done and color.
interface face_scan_sequencer_if;
  logic        start;
  logic        move_done;
  logic [2:0]  color;
  logic        move_req;
  logic [3:0]  pos;
  logic        busy;
  logic        done;
  logic [26:0] face;
  logic [8:0]  err_mask;

  modport master (
    output start, move_done, color,
    input  move_req, pos, busy, done, face, err_mask
  );

  modport slave (
    input  start, move_done, color,
    output move_req, pos, busy, done, face, err_mask
  );
endinterface

// File: rtl/face_scan_sequencer.sv
// Scans nine facelets (move, settle, debounce, store) into a 27-bit face word plus error mask; all outputs registered.
// Per facelet: MOVE until move_done, SETTLE_CYCLES, up to TIMEOUT sample cycles, one store cycle; start is ignored while busy.
module face_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int MATCH_COUNT   = 8,
  parameter int TIMEOUT       = 4096
) (
  input logic                  clk,
  input logic                  rst,
  face_scan_sequencer_if.slave bus
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [7:0]  MATCH_N     = 8'(MATCH_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    SETTLE,
    SAMPLE,
    STORE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [15:0] settle_cnt;
  logic [15:0] tmo_cnt;
  logic [7:0]  run;
  logic [7:0]  run_nx;
  logic [2:0]  last;
  logic [2:0]  last_nx;
  logic        match;
  logic        store_err;

  logic [3:0]  pos_q;
  logic [26:0] face_q;
  logic [8:0]  err_q;
  logic        move_req_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Debounce evaluation runs every cycle; its result is only consumed in SAMPLE.
  always_comb begin
    state_nx = state;
    run_nx   = run;
    last_nx  = last;

    if (bus.color >= 3'd6) begin
      run_nx = 8'd0;
    end else if (run != 8'd0 && bus.color == last) begin
      run_nx = run + 8'd1;
    end else begin
      run_nx  = 8'd1;
      last_nx = bus.color;
    end
    match = (run_nx == MATCH_N);

    case (state)
      IDLE:    if (bus.start) state_nx = MOVE;
      MOVE:    if (bus.move_done) state_nx = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nx = SAMPLE;
      SAMPLE:  if (match || tmo_cnt == TMO_LAST) state_nx = STORE;
      STORE:   state_nx = (pos_q == 4'd8) ? DONE : MOVE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= 16'd0;
      tmo_cnt    <= 16'd0;
      run        <= 8'd0;
      last       <= 3'd0;
      store_err  <= 1'b0;
      pos_q      <= 4'd0;
      face_q     <= 27'd0;
      err_q      <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            pos_q  <= 4'd0;
            face_q <= 27'd0;
            err_q  <= 9'd0;
          end
        end
        MOVE: begin
          if (bus.move_done) settle_cnt <= 16'd0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 16'd1;
          if (settle_cnt == SETTLE_LAST) begin
            run     <= 8'd0;
            tmo_cnt <= 16'd0;
          end
        end
        SAMPLE: begin
          run       <= run_nx;
          last      <= last_nx;
          tmo_cnt   <= tmo_cnt + 16'd1;
          // A match on the final timeout cycle still counts as a clean read.
          store_err <= !match;
        end
        STORE: begin
          for (int i = 0; i < 9; i++) begin
            if (pos_q == 4'(i)) begin
              face_q[3*i +: 3] <= store_err ? 3'd7 : last;
              if (store_err) err_q[i] <= 1'b1;
            end
          end
          if (pos_q != 4'd8) pos_q <= pos_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      move_req_q <= (state_nx == MOVE);
      busy_q     <= (state_nx != IDLE);
      done_q     <= (state_nx == DONE);
    end
  end

  assign bus.move_req = move_req_q;
  assign bus.pos      = pos_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.face     = face_q;
  assign bus.err_mask = err_q;

endmodule

// File: tb/tb_face_scan_sequencer.sv
// Directed bench for face_scan_sequencer with a two-cycle motion model and per-facelet color scripts.
// SETTLE_CYCLES=4, MATCH_COUNT=3, TIMEOUT=16; a clean facelet with this motion model takes 2+4+3+1 = 10 cycles.
module tb_face_scan_sequencer;

  localparam int SETTLE = 4;
  localparam int MATCH  = 3;
  localparam int TMO    = 16;

  logic clk;
  logic rst;
  face_scan_sequencer_if bus ();

  face_scan_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .MATCH_COUNT  (MATCH),
    .TIMEOUT      (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_cmp;
  int          n_fail;
  int          scen;
  bit          stall;

  int          lat;
  int          done_cnt;
  int          rises;
  int          mr5;
  int          pos_changes;
  logic        busy_before;
  logic        busy_first;
  logic        mr_first;
  logic [3:0]  pos_first;
  logic        busy_at_done;
  logic        busy_after;
  logic [26:0] res_face;
  logic [8:0]  res_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Motion controller: move_done rises 2 cycles after move_req (52 at facelet 5 when stalling).
  initial begin
    int md_cnt;
    md_cnt = 0;
    bus.move_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.move_req) begin
        bus.move_done = 1'b0;
        md_cnt = 0;
      end else begin
        md_cnt++;
        if (md_cnt >= ((stall && bus.pos == 4'd5) ? 52 : 2)) bus.move_done = 1'b1;
      end
    end
  end

  function automatic logic [2:0] col_for(int s, logic [3:0] p, int k);
    logic [2:0] dbs [5];
    logic [2:0] inv [6];
    dbs = '{3'd2, 3'd2, 3'd4, 3'd4, 3'd4};
    inv = '{3'd1, 3'd1, 3'd6, 3'd1, 3'd1, 3'd1};
    if (k < 0) return 3'd6;
    if (s == 1 && p == 4'd3) return dbs[(k > 4) ? 4 : k];
    if (s == 2 && p == 4'd0) return inv[(k > 5) ? 5 : k];
    if (s == 3 && p == 4'd7) return (k % 2 == 1) ? 3'd3 : 3'd0;
    return 3'd5;
  endfunction

  // Classifier: k counts the upcoming edge relative to the first SAMPLE edge after move_req falls.
  initial begin
    int   sidx;
    logic prev_mr;
    sidx = -1000;
    prev_mr = 1'b0;
    bus.color = 3'd6;
    forever begin
      @(negedge clk);
      if (rst) begin
        sidx = -1000;
        prev_mr = 1'b0;
      end else begin
        if (prev_mr && !bus.move_req) sidx = -SETTLE;
        else sidx++;
        prev_mr = bus.move_req;
      end
      bus.color = col_for(scen, bus.pos, sidx);
    end
  end

  task automatic run_scan(input int s, input bit inject, input bit do_stall);
    logic       prev_mr;
    logic [3:0] prev_pos;
    bit         injected;
    scen = s;
    stall = do_stall;
    lat = -1;
    done_cnt = 0;
    mr5 = 0;
    pos_changes = 0;
    busy_at_done = 1'bx;
    busy_after = 1'bx;
    injected = 0;
    @(negedge clk);
    busy_before = bus.busy;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_first = bus.busy;
    mr_first = bus.move_req;
    pos_first = bus.pos;
    rises = bus.move_req ? 1 : 0;
    prev_mr = bus.move_req;
    prev_pos = bus.pos;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (bus.start) bus.start = 1'b0;
      if (inject && !injected && bus.pos == 4'd2) begin
        bus.start = 1'b1;
        injected = 1;
      end
      if (bus.move_req && !prev_mr) rises++;
      if (bus.move_req && bus.pos == 4'd5) mr5++;
      if (bus.pos != prev_pos) pos_changes++;
      prev_mr = bus.move_req;
      prev_pos = bus.pos;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = cyc;
          busy_at_done = bus.busy;
        end
      end
      if (lat >= 0 && cyc == lat + 1) busy_after = bus.busy;
      if (lat >= 0 && cyc >= lat + 4) break;
    end
    bus.start = 1'b0;
    res_face = bus.face;
    res_err = bus.err_mask;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.pos !== 4'd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", bus.pos); end
    n_cmp++; if (bus.face !== 27'd0) begin n_fail++; $display("FAIL reset_face: got %o want 0", bus.face); end
    n_cmp++; if (bus.err_mask !== 9'd0) begin n_fail++; $display("FAIL reset_err: got %h want 0", bus.err_mask); end
    n_cmp++; if (bus.move_req !== 1'b0) begin n_fail++; $display("FAIL reset_move_req: got %b want 0", bus.move_req); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.move_req !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: got busy=%b move_req=%b want 0/0", bus.busy, bus.move_req); end
  endtask

  task automatic test_clean_scan;
    run_scan(0, 0, 0);
    n_cmp++; if (busy_before !== 1'b0) begin n_fail++; $display("FAIL clean_busy_before: got %b want 0", busy_before); end
    n_cmp++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL clean_busy_rise: got %b want 1", busy_first); end
    n_cmp++; if (mr_first !== 1'b1) begin n_fail++; $display("FAIL clean_move_req_rise: got %b want 1", mr_first); end
    n_cmp++; if (pos_first !== 4'd0) begin n_fail++; $display("FAIL clean_pos_first: got %0d want 0", pos_first); end
    n_cmp++; if (lat != 9 * (2 + SETTLE + MATCH + 1)) begin n_fail++; $display("FAIL clean_latency: got %0d want %0d", lat, 9 * (2 + SETTLE + MATCH + 1)); end
    n_cmp++; if (rises != 9) begin n_fail++; $display("FAIL clean_moves: got %0d want 9", rises); end
    n_cmp++; if (pos_changes != 8) begin n_fail++; $display("FAIL clean_pos_steps: got %0d want 8", pos_changes); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL clean_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL clean_busy_fall: got %b/%b want 1/0", busy_at_done, busy_after); end
    n_cmp++; if (res_face !== 27'o555555555) begin n_fail++; $display("FAIL clean_face: got %o want 555555555", res_face); end
    n_cmp++; if (res_err !== 9'h000) begin n_fail++; $display("FAIL clean_err: got %h want 000", res_err); end
  endtask

  task automatic test_debounce;
    run_scan(1, 0, 0);
    n_cmp++; if (lat != 92) begin n_fail++; $display("FAIL debounce_latency: got %0d want 92", lat); end
    n_cmp++; if (res_face !== 27'o555554555) begin n_fail++; $display("FAIL debounce_face: got %o want 555554555", res_face); end
    n_cmp++; if (res_face[11:9] !== 3'd4) begin n_fail++; $display("FAIL debounce_facelet3: got %0d want 4", res_face[11:9]); end
    n_cmp++; if (res_err !== 9'h000) begin n_fail++; $display("FAIL debounce_err: got %h want 000", res_err); end
  endtask

  task automatic test_invalid_code;
    run_scan(2, 0, 0);
    n_cmp++; if (lat != 93) begin n_fail++; $display("FAIL invalid_latency: got %0d want 93", lat); end
    n_cmp++; if (res_face !== 27'o555555551) begin n_fail++; $display("FAIL invalid_face: got %o want 555555551", res_face); end
    n_cmp++; if (res_err !== 9'h000) begin n_fail++; $display("FAIL invalid_err: got %h want 000", res_err); end
  endtask

  task automatic test_timeout;
    run_scan(3, 0, 0);
    n_cmp++; if (lat != 90 + (TMO - MATCH)) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", lat, 90 + (TMO - MATCH)); end
    n_cmp++; if (res_face !== 27'o575555555) begin n_fail++; $display("FAIL timeout_face: got %o want 575555555", res_face); end
    n_cmp++; if (res_err !== 9'h080) begin n_fail++; $display("FAIL timeout_err: got %h want 080", res_err); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL timeout_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back;
    run_scan(0, 1, 1);
    n_cmp++; if (lat != 140) begin n_fail++; $display("FAIL stall_latency: got %0d want 140", lat); end
    n_cmp++; if (mr5 != 52) begin n_fail++; $display("FAIL stall_move_req_held: got %0d want 52", mr5); end
    n_cmp++; if (rises != 9 || pos_changes != 8) begin n_fail++; $display("FAIL stall_sequence: got moves=%0d steps=%0d want 9/8", rises, pos_changes); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (res_face !== 27'o555555555 || res_err !== 9'h000) begin n_fail++; $display("FAIL stall_result: got %o/%h want 555555555/000", res_face, res_err); end
    stall = 0;
  endtask

  task automatic test_reset_mid;
    bit seen_mr;
    bit found;
    scen = 0;
    stall = 0;
    seen_mr = 0;
    found = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.pos == 4'd4 && bus.move_req) seen_mr = 1;
      if (seen_mr && !bus.move_req) begin
        found = 1;
        break;
      end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL midreset_reach_settle: got no SETTLE at pos 4 want one within 500 cycles"); end
    n_cmp++; if (bus.face !== 27'o000005555) begin n_fail++; $display("FAIL midreset_partial: got %o want 000005555", bus.face); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.face !== 27'd0 || bus.err_mask !== 9'd0) begin n_fail++; $display("FAIL midreset_clear: got %o/%h want 0/0", bus.face, bus.err_mask); end
    n_cmp++; if (bus.pos !== 4'd0) begin n_fail++; $display("FAIL midreset_pos: got %0d want 0", bus.pos); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.move_req !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got busy=%b mr=%b done=%b want 0", bus.busy, bus.move_req, bus.done); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_scan(0, 0, 0);
    n_cmp++; if (lat != 90 || rises != 9) begin n_fail++; $display("FAIL midreset_rescan: got lat=%0d moves=%0d want 90/9", lat, rises); end
    n_cmp++; if (res_face !== 27'o555555555 || res_err !== 9'h000) begin n_fail++; $display("FAIL midreset_result: got %o/%h want 555555555/000", res_face, res_err); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    n_cmp = 0;
    n_fail = 0;
    scen = 0;
    stall = 0;
    test_reset();
    test_clean_scan();
    test_debounce();
    test_invalid_code();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/face_scan_sequencer.md
# face_scan_sequencer

Sequences the reading of one cube face: steps the sensor carriage across the nine facelet positions, waits for the optics to settle, and debounces the registered 3-bit color code from the color classifier. It assembles a 27-bit face word with a per-facelet error mask. It sits between the top-level solve FSM (start/done), the motion controller (move_req/move_done) and the classifier output.

## Interface
- SETTLE_CYCLES, 1000: cycles to wait after move_done before sampling (1..65535)
- MATCH_COUNT, 8: consecutive identical valid codes required to accept a facelet (2..255)
- TIMEOUT, 4096: maximum SAMPLE cycles per facelet before forcing an error (> MATCH_COUNT, ≤ 65535)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request to scan a face; ignored unless idle
- move_done  in  1  motion controller: carriage has reached pos
- color  in  3  classifier code (0 W, 1 O, 2 G, 3 R, 4 B, 5 Y; 6–7 invalid)
- move_req  out  1  request carriage move to pos; held until move_done
- pos  out  4  facelet index 0..8, row-major
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: face/err_mask valid
- face  out  27  facelet i color at bits [3i+2:3i]
- err_mask  out  9  bit i set: facelet i timed out

## Operation
- Reset (async): state IDLE. pos=0, face=0, err_mask=0, move_req=0, busy=0, done=0. All counters and the run register clear.
- IDLE: start=1 → MOVE. Same edge: pos=0, face=0, err_mask=0.
- MOVE: move_req=1. move_done=1 sampled at an edge → SETTLE and clear settle counter. move_done is ignored in every other state.
- SETTLE: count SETTLE_CYCLES cycles, then → SAMPLE. Clear run and the timeout counter.
- SAMPLE, each cycle:
  - color ≥ 6: run=0.
  - Otherwise, if run≠0 and color==last: run+1. Else run=1, last=color.
  - When run would reach MATCH_COUNT → STORE(ok, last=color).
  - Timeout counter increments every SAMPLE cycle. At TIMEOUT without a match → STORE(err).
- STORE, one cycle:
  - Write face[3·pos+:3] = last for ok, or 3'd7 for err. Set err_mask[pos] on err.
  - pos==8 → DONE. Otherwise pos+1 → MOVE.
- DONE: done=1 for one cycle → IDLE. face, err_mask and pos hold until the next accepted start.
- start while busy: ignored, with no effect on state.
- Counters are 16 bits; run is 8 bits. No wrap is possible within the parameter ranges.

## Timing
- All outputs are registered.
- busy and move_req rise the cycle after start is sampled.
- MOVE lasts ≥1 cycle. When move_done is already high on MOVE entry, MOVE exits after 1 cycle.
- Facelet cycle with immediate move_done and a clean color: 1 (MOVE) + SETTLE_CYCLES + MATCH_COUNT (SAMPLE) + 1 (STORE).
- Facelet cycle on timeout: 1 + SETTLE_CYCLES + TIMEOUT + 1.
- done rises 1 cycle after the STORE with pos=8. busy falls together with done's falling edge, i.e. in the first IDLE cycle.
- A match and a timeout in the same cycle resolve as a match.
- Reset asserted mid-scan aborts immediately: move_req drops asynchronously, and face/err_mask clear. The partial face is never reported.

## Test plan
Bench parameters: SETTLE_CYCLES=4, MATCH_COUNT=3, TIMEOUT=16; move_done returned 2 cycles after move_req.
- Clean scan: color held at 5 for all nine facelets, start pulse → nine move_req cycles with pos 0..8, done once. face=27'o555555555, err_mask=0, total latency checked against the formula.
- Debounce: facelet 3 sees 2,2,4,4,4 after settle → stored 4 exactly on the third 4, and face[11:9]=4.
- Invalid code: facelet 0 sees 1,1,6,1,1,1 → run resets at 6. Accept occurs on the third 1 after the 6; stored 1.
- Timeout: facelet 7 alternates 0/3 every cycle → after 16 SAMPLE cycles face[23:21]=7 and err_mask=9'h080. Scan continues to done.
- Start ignored while busy, plus stall: start pulses at facelet 2, and move_done is withheld 50 cycles at facelet 5 → no restart. move_req is held throughout, pos=5 is stable, and the final result is correct.
- Reset mid-scan: assert reset during SETTLE of facelet 4 → outputs go to reset values at once. A new start then produces a full correct scan from pos 0.
